// File: rtl/evt_conditioner_if.sv
// Port bundle for evt_conditioner: raw input and enable in, conditioned
// event/level/glitch outputs plus a debug copy of the FSM state.
// Signalling: there is no valid/ready handshake on this bundle. raw_in is
// sampled every cycle, evt_out and glitch_out are single-cycle pulses that
// cannot be back-pressured, and level_out/state_dbg are plain levels.
interface evt_conditioner_if;
  logic       raw_in;
  logic       enable_in;
  logic       evt_out;
  logic       level_out;
  logic       glitch_out;
  logic [1:0] state_dbg;

  modport master (
    output raw_in, enable_in,
    input  evt_out, level_out, glitch_out, state_dbg
  );

  modport slave (
    input  raw_in, enable_in,
    output evt_out, level_out, glitch_out, state_dbg
  );
endinterface

// File: rtl/evt_conditioner.sv
// Event conditioner: synchronizes a raw asynchronous input, debounces it
// with a stability counter driven by a four-state FSM, and emits a
// one-cycle event on the accepted edge direction(s). Aborted pending
// transitions are reported as one-cycle glitch pulses.
module evt_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int EDGE_MODE       = 0
) (
  input logic              clk_in,
  input logic              rst_in,
  evt_conditioner_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic RISE_EN = 1'((EDGE_MODE == 0) || (EDGE_MODE == 2));
  localparam logic FALL_EN = 1'((EDGE_MODE == 1) || (EDGE_MODE == 2));

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_evt;
  logic                   w_evt_nxt;
  logic                   r_glitch;
  logic                   w_glitch_nxt;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchronizer chain, FSM state, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_sync   <= '0;
      r_state  <= STABLE_LO;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_evt    <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.raw_in};
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_evt    <= w_evt_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  // Debounce FSM: pend on a change of the synchronized input, commit after
  // DEBOUNCE_CYCLES consecutive matching samples, abort on any reversal.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_level;
    w_evt_nxt    = 1'b0;
    w_glitch_nxt = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = STABLE_HI;
            w_level_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_evt_nxt   = bus.enable_in & RISE_EN;
          end else begin
            w_state_nxt = PEND_HI;
            w_cnt_nxt   = C_ONE;
          end
        end
      end
      PEND_HI: begin
        if (w_s) begin
          if (r_cnt == C_LAST) begin
            w_state_nxt = STABLE_HI;
            w_level_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_evt_nxt   = bus.enable_in & RISE_EN;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end else begin
          w_state_nxt  = STABLE_LO;
          w_cnt_nxt    = '0;
          w_glitch_nxt = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = STABLE_LO;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_evt_nxt   = bus.enable_in & FALL_EN;
          end else begin
            w_state_nxt = PEND_LO;
            w_cnt_nxt   = C_ONE;
          end
        end
      end
      PEND_LO: begin
        if (!w_s) begin
          if (r_cnt == C_LAST) begin
            w_state_nxt = STABLE_LO;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_evt_nxt   = bus.enable_in & FALL_EN;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end else begin
          w_state_nxt  = STABLE_HI;
          w_cnt_nxt    = '0;
          w_glitch_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.evt_out    = r_evt;
  assign bus.level_out  = r_level;
  assign bus.glitch_out = r_glitch;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_evt_conditioner.sv
// Directed bench for evt_conditioner. Three instances: A (mode 0, 4 cycles),
// B (mode 2, 4 cycles) and C (mode 0, 1 cycle). Inputs are driven and
// outputs checked 2 time units after each rising edge; edge numbering in
// the comments counts the first edge that captures a new raw value as 0.
module tb_evt_conditioner;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  evt_conditioner_if if_a ();
  evt_conditioner_if if_b ();
  evt_conditioner_if if_c ();

  evt_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut_a (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (if_a.slave)
  );
  evt_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut_b (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (if_b.slave)
  );
  evt_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) dut_c (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (if_c.slave)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int evt_cnt_a = 0, evt_cnt_b = 0, evt_cnt_c = 0;
  int glt_cnt_a = 0, glt_cnt_c = 0;
  int both_cnt  = 0;
  int ea, eb, ec, ga;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (if_a.evt_out === 1'b1)    evt_cnt_a++;
    if (if_b.evt_out === 1'b1)    evt_cnt_b++;
    if (if_c.evt_out === 1'b1)    evt_cnt_c++;
    if (if_a.glitch_out === 1'b1) glt_cnt_a++;
    if (if_c.glitch_out === 1'b1) glt_cnt_c++;
    if ((if_a.evt_out === 1'b1 && if_a.glitch_out === 1'b1) ||
        (if_b.evt_out === 1'b1 && if_b.glitch_out === 1'b1) ||
        (if_c.evt_out === 1'b1 && if_c.glitch_out === 1'b1))
      both_cnt++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_a.raw_in = 1'b0; if_a.enable_in = 1'b1;
    if_b.raw_in = 1'b0; if_b.enable_in = 1'b1;
    if_c.raw_in = 1'b0; if_c.enable_in = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_lvl_a", 32'(if_a.level_out), 0);
    check("rst_evt_a", 32'(if_a.evt_out), 0);
    check("rst_glt_a", 32'(if_a.glitch_out), 0);
    check("rst_st_a",  32'(if_a.state_dbg), 0);
    check("rst_lvl_b", 32'(if_b.level_out), 0);
    check("rst_lvl_c", 32'(if_c.level_out), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // 1. Clean rising edge, mode 0
    if_a.raw_in = 1'b1;
    step();                      // edge 0
    repeat (4) step();           // edges 1..4
    check("t1_lvl_e4", 32'(if_a.level_out), 0);
    check("t1_evt_e4", 32'(if_a.evt_out), 0);
    step();                      // edge 5 commit
    check("t1_lvl_e5", 32'(if_a.level_out), 1);
    check("t1_evt_e5", 32'(if_a.evt_out), 1);
    check("t1_st_e5",  32'(if_a.state_dbg), 2);
    step();
    check("t1_evt_e6", 32'(if_a.evt_out), 0);
    check("t1_lvl_e6", 32'(if_a.level_out), 1);
    repeat (4) step();
    ea = evt_cnt_a;
    if_a.raw_in = 1'b0;
    repeat (5) step();           // edges 0..4 of fall
    check("t1_fall_lvl_e4", 32'(if_a.level_out), 1);
    step();                      // edge 5
    check("t1_fall_lvl_e5", 32'(if_a.level_out), 0);
    check("t1_fall_evt_e5", 32'(if_a.evt_out), 0);
    repeat (3) step();
    check("t1_fall_evt_cnt", 32'(evt_cnt_a - ea), 0);

    // 2. Bounce rejection
    ea = evt_cnt_a; ga = glt_cnt_a;
    if_a.raw_in = 1'b1; step(); step();
    if_a.raw_in = 1'b0; step();
    if_a.raw_in = 1'b1; step();  // final rising capture (F0)
    check("t2_lvl_f0", 32'(if_a.level_out), 0);
    step();                      // F1: abort visible
    check("t2_glt_f1", 32'(if_a.glitch_out), 1);
    check("t2_lvl_f1", 32'(if_a.level_out), 0);
    repeat (3) step();           // F4
    check("t2_evt_f4", 32'(if_a.evt_out), 0);
    check("t2_lvl_f4", 32'(if_a.level_out), 0);
    step();                      // F5
    check("t2_evt_f5", 32'(if_a.evt_out), 1);
    check("t2_lvl_f5", 32'(if_a.level_out), 1);
    repeat (3) step();
    check("t2_glt_cnt", 32'(glt_cnt_a - ga), 1);
    check("t2_evt_cnt", 32'(evt_cnt_a - ea), 1);

    // 4. Enable gating
    if_a.raw_in = 1'b0;
    repeat (10) step();
    check("t4_lvl_lo", 32'(if_a.level_out), 0);
    ea = evt_cnt_a;
    if_a.enable_in = 1'b0;
    if_a.raw_in = 1'b1;
    repeat (6) step();           // edges 0..5
    check("t4_lvl_e5", 32'(if_a.level_out), 1);
    check("t4_evt_e5", 32'(if_a.evt_out), 0);
    if_a.enable_in = 1'b1;
    repeat (4) step();
    check("t4_evt_cnt", 32'(evt_cnt_a - ea), 0);

    // 5. Reset mid-pend
    if_a.raw_in = 1'b0;
    repeat (10) step();
    check("t5_lvl_lo", 32'(if_a.level_out), 0);
    if_a.raw_in = 1'b1;
    repeat (3) step();           // edges 0..2
    check("t5_st_pend", 32'(if_a.state_dbg), 1);
    rst_n = 1'b0;
    step();                      // edge 3 under reset
    check("t5_rst_lvl", 32'(if_a.level_out), 0);
    check("t5_rst_evt", 32'(if_a.evt_out), 0);
    check("t5_rst_glt", 32'(if_a.glitch_out), 0);
    check("t5_rst_st",  32'(if_a.state_dbg), 0);
    rst_n = 1'b1;
    ea = evt_cnt_a;
    repeat (5) step();           // release edges R0..R4
    check("t5_evt_r4", 32'(if_a.evt_out), 0);
    step();                      // R5
    check("t5_evt_r5", 32'(if_a.evt_out), 1);
    check("t5_lvl_r5", 32'(if_a.level_out), 1);
    repeat (3) step();
    check("t5_evt_cnt", 32'(evt_cnt_a - ea), 1);

    // 3. Mode 2 toggles
    eb = evt_cnt_b;
    for (int t = 0; t < 4; t++) begin
      if_b.raw_in = (t % 2 == 0);
      step();                    // edge 0
      repeat (4) step();
      check("t3_evt_e4", 32'(if_b.evt_out), 0);
      step();                    // edge 5
      check("t3_evt_e5", 32'(if_b.evt_out), 1);
      check("t3_lvl_e5", 32'(if_b.level_out), 32'((t % 2 == 0) ? 1 : 0));
      repeat (4) step();
    end
    repeat (2) step();
    check("t3_evt_cnt", 32'(evt_cnt_b - eb), 4);

    // 6. DEBOUNCE_CYCLES = 1, single-cycle pulse
    ec = evt_cnt_c;
    if_c.raw_in = 1'b1; step();  // edge 0
    if_c.raw_in = 1'b0; step();  // edge 1
    check("t6_lvl_e1", 32'(if_c.level_out), 0);
    step();                      // edge 2
    check("t6_lvl_e2", 32'(if_c.level_out), 1);
    check("t6_evt_e2", 32'(if_c.evt_out), 1);
    step();                      // edge 3
    check("t6_lvl_e3", 32'(if_c.level_out), 0);
    check("t6_evt_e3", 32'(if_c.evt_out), 0);
    repeat (3) step();
    check("t6_evt_cnt", 32'(evt_cnt_c - ec), 1);
    check("t6_glt_cnt", 32'(glt_cnt_c), 0);

    // evt/glitch exclusivity over the whole run
    check("excl_cnt", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/evt_conditioner.md
# evt_conditioner

Front-end stage that turns a raw, asynchronous, bouncy input (push-button, sensor comparator, encoder line) into clean single-cycle event pulses for the event counter downstream. It synchronizes the input, debounces it with a stability counter and a four-state FSM, and emits `evt_out` on the selected qualified edge(s). It also reports rejected bounces so firmware can monitor input quality.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flip-flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable samples required to accept a transition; legal ≥1.
- `EDGE_MODE`, default 0: 0 = rising edges only, 1 = falling edges only, 2 = both edges.
- `clk_in`  input  1  system clock; all logic on its rising edge.
- `rst_in`  input  1  synchronous, active-low reset.
- `raw_in`  input  1  asynchronous raw signal.
- `enable_in`  input  1  when low, `evt_out` is suppressed; `level_out` and the FSM keep tracking.
- `evt_out`  output  1  one-cycle pulse per accepted transition that matches `EDGE_MODE`.
- `level_out`  output  1  debounced level.
- `glitch_out`  output  1  one-cycle pulse when a pending transition is aborted.

## Operation
- The synchronizer is a shift chain of `SYNC_STAGES` flops. `s` is the last stage.
- The stability counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and unsigned. It never wraps: it is cleared before it can reach `DEBOUNCE_CYCLES`.
- FSM states: `STABLE_LO`, `PEND_HI`, `STABLE_HI`, `PEND_LO`.
  - `STABLE_LO`, `s`=1: if `DEBOUNCE_CYCLES`==1, commit high. Otherwise go to `PEND_HI` with `cnt`=1.
  - `PEND_HI`, `s`=1: if `cnt`==`DEBOUNCE_CYCLES`-1, commit high and go to `STABLE_HI`. Otherwise increment `cnt`.
  - `PEND_HI`, `s`=0: return to `STABLE_LO`, clear `cnt`, pulse `glitch_out`.
  - `STABLE_HI` and `PEND_LO` mirror the above with polarities swapped.
- On commit:
  - `level_out` takes the new value.
  - `evt_out` pulses if `enable_in` is high at the committing edge and the edge direction matches `EDGE_MODE`.
  - `cnt` is cleared.
- `enable_in` never affects state, `level_out` or `glitch_out`. Events committed while it is low are dropped, not queued.
- `evt_out` and `glitch_out` are never high in the same cycle.

## Timing
- Reset (`rst_in`=0 at a clock edge):
  - sync chain = 0, state = `STABLE_LO`, `cnt` = 0;
  - `level_out` = 0, `evt_out` = 0, `glitch_out` = 0.
  - Reset takes priority over all other activity, including mid-pend: the pending transition is discarded and no pulse is emitted.
- After reset release with `raw_in` held high, the FSM treats the input as a genuine rising transition. It commits it and pulses `evt_out` if `EDGE_MODE` is 0 or 2.
- Latency: if `raw_in` changes and is first captured at edge 0, and stays stable:
  - `s` changes after edge `SYNC_STAGES`-1;
  - commit happens at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1;
  - `level_out` and `evt_out` are high in the following cycle; `evt_out` lasts exactly 1 cycle.
- Minimum spacing between two `evt_out` pulses is 2×`DEBOUNCE_CYCLES` cycles for `EDGE_MODE` 0/1, and `DEBOUNCE_CYCLES` cycles for mode 2.
- `glitch_out` is registered and appears in the cycle after the aborting edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench parameters unless noted: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.
1. **Clean rising edge, `EDGE_MODE`=0, `enable_in`=1.** Reset, then drive `raw_in` 0→1 captured at edge 0 and hold → `level_out` and `evt_out` go high after edge 5; `evt_out` is high for exactly one cycle. A later 1→0 transition gives `level_out`=0 after its edge 5 and no `evt_out`.
2. **Bounce rejection.** Drive `raw_in` high for 2 cycles, low for 1, then high steady → `glitch_out` pulses once; `level_out` stays 0 during the bounce; a single `evt_out` occurs 5 edges after the final rising capture.
3. **`EDGE_MODE`=2 toggle.** Toggle `raw_in` every 10 cycles for 4 transitions → exactly 4 `evt_out` pulses, each 5 edges after its capture; `level_out` follows each transition.
4. **Enable gating.** Hold `enable_in`=0 across a rising commit → `level_out` rises and `evt_out` stays 0. Raise `enable_in` afterwards → no late pulse.
5. **Reset mid-pend.** Assert `rst_in`=0 at edge 3 of a pending rise → all outputs are 0 next cycle. With `raw_in` still high after release, one `evt_out` occurs 5 edges after release.
6. **`DEBOUNCE_CYCLES`=1.** A 1-cycle `raw_in` pulse → `level_out` high for 1 cycle, `evt_out` one pulse at edge 2, `glitch_out` never asserts.
